network_interface: RTL and testbench

//  Node-side network interface: the responder to the processor's NI handshake (proc_valid/mips_ni out, data_valid/proc_ready_in in).
//  TX path: buffers processor words, packetises as {dest,src,payload} flits, sends to router. RX path: buffers router flits for processor.
//  One instance per mesh node, between the MIPS core and its router port.

---
 rtl/network_interface.sv | 98 +++++++++
 tb/tb_network_interface.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/network_interface.sv
// network_interface: processor<->router NI with TX/RX show-ahead FIFOs; push at edge N is visible at N+1, valid/ready backpressure on both sides.
// Optional build macro NI_LOOPBACK_EN: self-addressed TX heads skip the router and go straight into the RX FIFO.
module network_interface #(
  parameter int DATA_W     = 32,
  parameter int NODE_W     = 2,
  parameter int NODE_ID    = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_W-1:0]          proc_data,
  input  logic [NODE_W-1:0]          proc_dest,
  input  logic                       proc_valid,
  output logic                       mips_ni,
  output logic [DATA_W-1:0]          ni_data,
  output logic [NODE_W-1:0]          ni_src,
  output logic                       data_valid,
  input  logic                       proc_ready_in,
  output logic [DATA_W+2*NODE_W-1:0] tx_flit,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  input  logic [DATA_W+2*NODE_W-1:0] rx_flit,
  input  logic                       rx_valid,
  output logic                       rx_ready,
  output logic [7:0]                 drop_cnt
);
  localparam int FW = DATA_W + 2*NODE_W;
  localparam int RW = DATA_W + NODE_W;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [NODE_W-1:0] MY_ID   = NODE_W'(NODE_ID);
  localparam logic [PW-1:0]     PTR_ONE = PW'(1);

  logic [FW-1:0] tx_mem [FIFO_DEPTH];
  logic [RW-1:0] rx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic [FW-1:0] tx_head;
  logic [RW-1:0] rx_head, rx_wdata;
  logic          tx_push, tx_pop, rx_acc, rx_match, rx_push, rx_pop;
  logic          lb_pending, lb_write;

  // The wrap bit separates full (same index, different lap) from empty.
  assign tx_full  = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
  assign tx_empty = (tx_wp == tx_rp);
  assign rx_full  = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
  assign rx_empty = (rx_wp == rx_rp);

  assign tx_head = tx_mem[tx_rp[AW-1:0]];
  assign rx_head = rx_mem[rx_rp[AW-1:0]];

`ifdef NI_LOOPBACK_EN
  assign lb_pending = rst_n && !tx_empty && (tx_head[FW-1 -: NODE_W] == MY_ID);
  assign lb_write   = lb_pending && !rx_full;
`else
  assign lb_pending = 1'b0;
  assign lb_write   = 1'b0;
`endif

  assign mips_ni  = rst_n && !tx_full;
  assign tx_valid = rst_n && !tx_empty && !lb_pending;
  assign tx_flit  = tx_head;
  assign tx_push  = proc_valid && mips_ni;
  assign tx_pop   = (tx_valid && tx_ready) || lb_write;

  // A pending loopback write owns the RX write port, so the router is stalled.
  assign rx_ready = rst_n && !rx_full && !lb_pending;
  assign rx_acc   = rx_valid && rx_ready;
  assign rx_match = (rx_flit[FW-1 -: NODE_W] == MY_ID);
  assign rx_push  = (rx_acc && rx_match) || lb_write;
  assign rx_wdata = lb_write ? tx_head[RW-1:0] : rx_flit[RW-1:0];

  assign data_valid = rst_n && !rx_empty;
  assign ni_data    = rx_head[DATA_W-1:0];
  assign ni_src     = rx_head[RW-1 -: NODE_W];
  assign rx_pop     = data_valid && proc_ready_in;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[AW-1:0]] <= {proc_dest, MY_ID, proc_data};
    if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_wp    <= '0;
      tx_rp    <= '0;
      rx_wp    <= '0;
      rx_rp    <= '0;
      drop_cnt <= 8'd0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + PTR_ONE;
      if (tx_pop)  tx_rp <= tx_rp + PTR_ONE;
      if (rx_push) rx_wp <= rx_wp + PTR_ONE;
      if (rx_pop)  rx_rp <= rx_rp + PTR_ONE;
      if (rx_acc && !rx_match && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_network_interface.sv
// Directed bench for network_interface (NODE_ID=0, 32-bit payload, 2-bit node ids, depth 4).
module tb_network_interface;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] proc_data;
  logic [1:0]  proc_dest;
  logic        proc_valid;
  logic        mips_ni;
  logic [31:0] ni_data;
  logic [1:0]  ni_src;
  logic        data_valid;
  logic        proc_ready_in;
  logic [35:0] tx_flit;
  logic        tx_valid;
  logic        tx_ready;
  logic [35:0] rx_flit;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  drop_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  network_interface dut (
    .clk(clk), .rst_n(rst_n),
    .proc_data(proc_data), .proc_dest(proc_dest), .proc_valid(proc_valid), .mips_ni(mips_ni),
    .ni_data(ni_data), .ni_src(ni_src), .data_valid(data_valid), .proc_ready_in(proc_ready_in),
    .tx_flit(tx_flit), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_flit(rx_flit), .rx_valid(rx_valid), .rx_ready(rx_ready), .drop_cnt(drop_cnt)
  );

  typedef struct {
    logic [31:0] pd;  logic [1:0] pdst; logic pv; logic pr; logic tr;
    logic [35:0] rf;  logic rv;
    logic e_mni; logic e_tv; logic [35:0] e_tf;
    logic e_dv;  logic [31:0] e_nd; logic [1:0] e_ns;
    logic e_rr;  logic [7:0] e_drop;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic [31:0] pd, input logic [1:0] pdst, input logic pv, input logic pr,
                   input logic tr, input logic [35:0] rf, input logic rv,
                   input logic e_mni, input logic e_tv, input logic [35:0] e_tf,
                   input logic e_dv, input logic [31:0] e_nd, input logic [1:0] e_ns,
                   input logic e_rr, input logic [7:0] e_drop);
    vec_t r;
    r.pd = pd; r.pdst = pdst; r.pv = pv; r.pr = pr; r.tr = tr; r.rf = rf; r.rv = rv;
    r.e_mni = e_mni; r.e_tv = e_tv; r.e_tf = e_tf; r.e_dv = e_dv; r.e_nd = e_nd;
    r.e_ns = e_ns; r.e_rr = e_rr; r.e_drop = e_drop;
    vecs.push_back(r);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    proc_valid = 1'b0; proc_data = '0; proc_dest = '0;
    proc_ready_in = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0; rx_flit = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();

    // Table: {inputs for one cycle} -> state seen just after that edge
    //  pd            dst pv pr tr rf             rv  mni tv tf             dv nd            ns  rr drop
    v(32'hDEADBEEF, 2, 1, 0, 0, 36'h0,          0,  1, 1, 36'h8DEADBEEF, 0, 32'h0,        0,  1, 0);
    v(32'h0,        0, 0, 0, 1, 36'h0,          0,  1, 0, 36'h0,         0, 32'h0,        0,  1, 0);
    v(32'h0,        0, 0, 0, 0, 36'h300001234,  1,  1, 0, 36'h0,         1, 32'h1234,     3,  1, 0);
    v(32'h0,        0, 0, 1, 0, 36'h0,          0,  1, 0, 36'h0,         0, 32'h0,        0,  1, 0);
    v(32'h11,       1, 1, 0, 0, 36'h0,          0,  1, 1, 36'h400000011, 0, 32'h0,        0,  1, 0);
    v(32'h22,       1, 1, 0, 0, 36'h0,          0,  1, 1, 36'h400000011, 0, 32'h0,        0,  1, 0);
    v(32'h33,       1, 1, 0, 0, 36'h0,          0,  1, 1, 36'h400000011, 0, 32'h0,        0,  1, 0);
    v(32'h44,       1, 1, 0, 0, 36'h0,          0,  0, 1, 36'h400000011, 0, 32'h0,        0,  1, 0);
    v(32'h55,       1, 1, 0, 0, 36'h0,          0,  0, 1, 36'h400000011, 0, 32'h0,        0,  1, 0);
    v(32'h0,        0, 0, 0, 1, 36'h0,          0,  1, 1, 36'h400000022, 0, 32'h0,        0,  1, 0);
    v(32'h0,        0, 0, 0, 1, 36'h0,          0,  1, 1, 36'h400000033, 0, 32'h0,        0,  1, 0);
    v(32'h0,        0, 0, 0, 1, 36'h0,          0,  1, 1, 36'h400000044, 0, 32'h0,        0,  1, 0);
    v(32'h0,        0, 0, 0, 1, 36'h0,          0,  1, 0, 36'h0,         0, 32'h0,        0,  1, 0);
    v(32'hA1,       1, 1, 0, 0, 36'h0,          0,  1, 1, 36'h4000000A1, 0, 32'h0,        0,  1, 0);
    v(32'hA2,       1, 1, 0, 0, 36'h0,          0,  1, 1, 36'h4000000A1, 0, 32'h0,        0,  1, 0);
    v(32'hA3,       1, 1, 0, 0, 36'h0,          0,  1, 1, 36'h4000000A1, 0, 32'h0,        0,  1, 0);
    v(32'hA4,       1, 1, 0, 0, 36'h0,          0,  0, 1, 36'h4000000A1, 0, 32'h0,        0,  1, 0);
    v(32'hA5,       1, 1, 0, 1, 36'h0,          0,  1, 1, 36'h4000000A2, 0, 32'h0,        0,  1, 0);
    v(32'h0,        0, 0, 0, 1, 36'h0,          0,  1, 1, 36'h4000000A3, 0, 32'h0,        0,  1, 0);
    v(32'h0,        0, 0, 0, 1, 36'h0,          0,  1, 1, 36'h4000000A4, 0, 32'h0,        0,  1, 0);
    v(32'h0,        0, 0, 0, 1, 36'h0,          0,  1, 0, 36'h0,         0, 32'h0,        0,  1, 0);
    v(32'h0,        0, 0, 0, 0, 36'h1000000B1,  1,  1, 0, 36'h0,         1, 32'hB1,       1,  1, 0);
    v(32'h0,        0, 0, 0, 0, 36'h2000000B2,  1,  1, 0, 36'h0,         1, 32'hB1,       1,  1, 0);
    v(32'h0,        0, 0, 0, 0, 36'h3000000B3,  1,  1, 0, 36'h0,         1, 32'hB1,       1,  1, 0);
    v(32'h0,        0, 0, 0, 0, 36'h1000000B4,  1,  1, 0, 36'h0,         1, 32'hB1,       1,  0, 0);
    v(32'h0,        0, 0, 0, 0, 36'h2000000B5,  1,  1, 0, 36'h0,         1, 32'hB1,       1,  0, 0);
    v(32'h0,        0, 0, 1, 0, 36'h0,          0,  1, 0, 36'h0,         1, 32'hB2,       2,  1, 0);
    v(32'h0,        0, 0, 1, 0, 36'h0,          0,  1, 0, 36'h0,         1, 32'hB3,       3,  1, 0);
    v(32'h0,        0, 0, 1, 0, 36'h0,          0,  1, 0, 36'h0,         1, 32'hB4,       1,  1, 0);
    v(32'h0,        0, 0, 1, 0, 36'h0,          0,  1, 0, 36'h0,         0, 32'h0,        0,  1, 0);
    v(32'h0,        0, 0, 0, 0, 36'hC000000D1,  1,  1, 0, 36'h0,         0, 32'h0,        0,  1, 1);

    // Reset held for two edges with proc_valid asserted
    proc_valid = 1'b1; proc_data = 32'hFFFF0000; proc_dest = 2'd1;
    step(); step();
    check("rst_mips_ni", mips_ni, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_data_valid", data_valid, 0);
    check("rst_rx_ready", rx_ready, 0);
    idle();
    rst_n = 1'b1;
    step();
    check("post_rst_mips_ni", mips_ni, 1);
    check("post_rst_drop_cnt", drop_cnt, 0);
    check("post_rst_tx_valid", tx_valid, 0);

    foreach (vecs[i]) begin
      proc_data = vecs[i].pd; proc_dest = vecs[i].pdst; proc_valid = vecs[i].pv;
      proc_ready_in = vecs[i].pr; tx_ready = vecs[i].tr;
      rx_flit = vecs[i].rf; rx_valid = vecs[i].rv;
      step();
      check($sformatf("v%0d_mips_ni", i), mips_ni, vecs[i].e_mni);
      check($sformatf("v%0d_tx_valid", i), tx_valid, vecs[i].e_tv);
      if (vecs[i].e_tv) check($sformatf("v%0d_tx_flit", i), tx_flit, vecs[i].e_tf);
      check($sformatf("v%0d_data_valid", i), data_valid, vecs[i].e_dv);
      if (vecs[i].e_dv) begin
        check($sformatf("v%0d_ni_data", i), ni_data, vecs[i].e_nd);
        check($sformatf("v%0d_ni_src", i), ni_src, vecs[i].e_ns);
      end
      check($sformatf("v%0d_rx_ready", i), rx_ready, vecs[i].e_rr);
      check($sformatf("v%0d_drop_cnt", i), drop_cnt, vecs[i].e_drop);
    end

    // Misroute flood: 299 more dest=1 flits after the one above (300 total)
    idle();
    rx_valid = 1'b1;
    for (int i = 0; i < 299; i++) begin
      rx_flit = 36'h400000000 | 36'(i);
      step();
      if (i + 2 == 254) check("drop_cnt_254", drop_cnt, 254);
    end
    idle();
    step();
    check("drop_cnt_sat", drop_cnt, 255);
    check("misroute_none_stored", data_valid, 0);

    // Reset mid-operation with both FIFOs occupied
    proc_valid = 1'b1; proc_data = 32'hEE; proc_dest = 2'd1;
    rx_valid = 1'b1; rx_flit = 36'h1000000EE;
    step();
    check("mid_tx_valid", tx_valid, 1);
    check("mid_data_valid", data_valid, 1);
    idle();
    rst_n = 1'b0;
    step();
    check("mid_rst_data_valid", data_valid, 0);
    rst_n = 1'b1;
    step();
    check("mid_post_tx_valid", tx_valid, 0);
    check("mid_post_data_valid", data_valid, 0);
    check("mid_post_drop_cnt", drop_cnt, 0);
    check("mid_post_mips_ni", mips_ni, 1);

`ifdef NI_LOOPBACK_EN
    proc_valid = 1'b1; proc_data = 32'hA5; proc_dest = 2'd0;
    step();
    idle();
    check("lb_tx_valid", tx_valid, 0);
    check("lb_rx_ready", rx_ready, 0);
    rx_valid = 1'b1; rx_flit = 36'h200000077;
    step();
    check("lb_tx_valid_after", tx_valid, 0);
    check("lb_first_valid", data_valid, 1);
    check("lb_first_data", ni_data, 32'hA5);
    check("lb_first_src", ni_src, 0);
    check("lb_rx_ready_after", rx_ready, 1);
    step();
    idle();
    proc_ready_in = 1'b1;
    step();
    check("lb_second_data", ni_data, 32'h77);
    check("lb_second_src", ni_src, 2);
    step();
    check("lb_drained", data_valid, 0);
`else
    proc_valid = 1'b1; proc_data = 32'hC0; proc_dest = 2'd0;
    step();
    idle();
    check("self_tx_valid", tx_valid, 1);
    check("self_tx_flit", tx_flit, 36'h0000000C0);
    check("self_rx_ready", rx_ready, 1);
    check("self_data_valid", data_valid, 0);
    tx_ready = 1'b1;
    step();
    check("self_tx_drained", tx_valid, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
